// File: rtl/clk_meas_pkg.sv
// Shared types and default constants for the clock period meter and its
// input synchroniser.
package clk_meas_pkg;

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } meas_state_t;

    localparam int CLK_HZ         = 100_000_000;
    localparam int EXP_PERIOD_10K = 10000;
    localparam int SYNC_STAGES    = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input, followed by a history
// flop that produces single-cycle rise/fall strobes in the clk domain.
module sync_edge_detect
    import clk_meas_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;
    logic              hist_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = async_in;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            hist_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~hist_reg;
    assign fall  = ~level & hist_reg;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk cycles,
// tracks lock against an expected period and flags a missing input clock.
module clock_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int EXP_PERIOD = EXP_PERIOD_10K,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  TOL_LO_C  = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0]  TOL_HI_C  = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [GOOD_W-1:0] GOOD_ONE  = {{(GOOD_W-1){1'b0}}, 1'b1};
    localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_CNT);

    logic level;
    logic rise;
    logic fall;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (clk_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    meas_state_t       state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  hcnt_reg;
    logic              fall_seen_reg;
    logic [GOOD_W-1:0] good_cnt_reg;
    logic [CNT_W-1:0]  period_reg;
    logic [CNT_W-1:0]  high_time_reg;
    logic              meas_valid_reg;
    logic              locked_reg;
    logic              timeout_reg;

    logic              in_tol;
    logic [GOOD_W-1:0] good_next;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  hcnt_inc;

    // Counters saturate at all-ones so a stuck input never wraps into a
    // plausible-looking measurement.
    assign cnt_inc   = (&cnt_reg)  ? cnt_reg  : cnt_reg  + CNT_ONE;
    assign hcnt_inc  = (&hcnt_reg) ? hcnt_reg : hcnt_reg + CNT_ONE;
    assign in_tol    = (cnt_reg >= TOL_LO_C) && (cnt_reg <= TOL_HI_C);
    assign good_next = (good_cnt_reg == LOCK_C) ? good_cnt_reg : good_cnt_reg + GOOD_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= WAIT_FIRST;
            cnt_reg        <= '0;
            hcnt_reg       <= '0;
            fall_seen_reg  <= 1'b0;
            good_cnt_reg   <= '0;
            period_reg     <= '0;
            high_time_reg  <= '0;
            meas_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
        end else if (clear) begin
            state_reg      <= WAIT_FIRST;
            cnt_reg        <= '0;
            hcnt_reg       <= '0;
            fall_seen_reg  <= 1'b0;
            good_cnt_reg   <= '0;
            period_reg     <= '0;
            high_time_reg  <= '0;
            meas_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            meas_valid_reg <= 1'b0;
            case (state_reg)
                WAIT_FIRST: begin
                    cnt_reg       <= '0;
                    hcnt_reg      <= '0;
                    fall_seen_reg <= 1'b0;
                    // First edge only provides the reference; nothing to report yet.
                    if (rise) begin
                        state_reg   <= MEASURE;
                        cnt_reg     <= CNT_ONE;
                        hcnt_reg    <= CNT_ONE;
                        timeout_reg <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_reg     <= cnt_reg;
                        high_time_reg  <= hcnt_reg;
                        meas_valid_reg <= 1'b1;
                        cnt_reg        <= CNT_ONE;
                        hcnt_reg       <= CNT_ONE;
                        fall_seen_reg  <= 1'b0;
                        if (in_tol) begin
                            good_cnt_reg <= good_next;
                            locked_reg   <= (good_next == LOCK_C);
                        end else begin
                            good_cnt_reg <= '0;
                            locked_reg   <= 1'b0;
                        end
                    end else if (cnt_reg >= TIMEOUT_C) begin
                        timeout_reg   <= 1'b1;
                        locked_reg    <= 1'b0;
                        good_cnt_reg  <= '0;
                        state_reg     <= WAIT_FIRST;
                        cnt_reg       <= '0;
                        hcnt_reg      <= '0;
                        fall_seen_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (level && !fall_seen_reg) begin
                            hcnt_reg <= hcnt_inc;
                        end
                        if (fall) begin
                            fall_seen_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= WAIT_FIRST;
            endcase
        end
    end

    assign period     = period_reg;
    assign high_time  = high_time_reg;
    assign meas_valid = meas_valid_reg;
    assign locked     = locked_reg;
    assign timeout    = timeout_reg;

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Receive-side checker for the divided clocks produced by the design's clock dividers (e.g. the 10 kHz tick derived from the 100 MHz board clock).
- Synchronises an asynchronous slow clock into the clk domain and measures its period and high time in clk cycles.
- Flags lock against an expected period and flags a missing clock (timeout).
- Used as an on-board self-check and as a debug feed for the seven-segment/LED readout.

Parameters:
- CNT_W, 32, width of all cycle counters and measurement outputs.
- EXP_PERIOD, 10000, expected clk_in period in clk cycles (100 MHz / 10 kHz).
- TOL, 2, allowed absolute deviation from EXP_PERIOD, in cycles, for a measurement to count as in-tolerance.
- LOCK_CNT, 4, consecutive in-tolerance measurements required to assert locked.
- TIMEOUT, 1000000, clk cycles without a clk_in rising edge before timeout is declared.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- clk_in, input, 1, asynchronous slow clock under measurement.
- clear, input, 1, synchronous soft restart, active high.
- period, output, CNT_W, last measured rising-to-rising interval in clk cycles.
- high_time, output, CNT_W, last measured rise-to-fall interval in clk cycles.
- meas_valid, output, 1, one-cycle pulse when period/high_time update.
- locked, output, 1, clk_in period within tolerance for LOCK_CNT consecutive measurements.
- timeout, output, 1, no clk_in rising edge for TIMEOUT cycles.

Behaviour:
- One clock is used. Reset is asynchronous and active-low: rst_n low clears all state immediately, independent of clk.
- Reset values: period=0, high_time=0, meas_valid=0, locked=0, timeout=0, state=WAIT_FIRST, all counters=0, synchroniser flops=0.
- Synchroniser: 2 flops, then 1 history flop.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - An input edge is detected 2-3 clk cycles after it occurs.
- FSM states: WAIT_FIRST, MEASURE.
  - WAIT_FIRST: cnt and hcnt held at 0. On rise: go to MEASURE, cnt<=1, hcnt<=1. No meas_valid, because there is no reference edge yet.
  - MEASURE: cnt increments every cycle. hcnt increments while s2=1 and no fall has been seen since the last rise.
  - MEASURE, on rise:
    - period <= cnt, high_time <= hcnt, meas_valid <= 1 on the next cycle (registered).
    - cnt <= 1, hcnt <= 1.
    - The rising-edge cycle itself counts toward the next interval.
- Lock tracking, on each measurement:
  - In-tolerance means |cnt - EXP_PERIOD| <= TOL, computed with unsigned compare: cnt >= EXP_PERIOD-TOL and cnt <= EXP_PERIOD+TOL.
  - In-tolerance: good_cnt increments, saturating at LOCK_CNT. locked <= 1 when good_cnt reaches LOCK_CNT.
  - Out-of-tolerance: good_cnt <= 0, locked <= 0 in the same update as meas_valid.
- Timeout: in MEASURE, when cnt reaches TIMEOUT with no rise:
  - timeout <= 1, locked <= 0, good_cnt <= 0, state <= WAIT_FIRST.
  - period and high_time keep their last values.
  - The next rise in WAIT_FIRST clears timeout.
  - Timeout is not armed in WAIT_FIRST, so a clk_in that never toggles after reset leaves timeout=0.
- Counter overflow: cnt and hcnt saturate at all-ones and never wrap. TIMEOUT must be less than 2^CNT_W-1.
- clear: synchronous, with priority over rise and timeout in the same cycle. It forces the reset values, except the synchroniser, which keeps sampling.
- Simultaneous rise and timeout in the same cycle: rise wins, and a normal measurement is taken.
- Stuck-high clk_in: hcnt saturates or tracks cnt. Timeout is still governed by the absence of a rise.
- meas_valid is never high for two consecutive cycles. This requires a clk_in period of at least 4 clk cycles; faster inputs are out of scope.

Decomposition:
- Package clk_meas_pkg holds:
  - the state enum type (WAIT_FIRST, MEASURE);
  - default constants CLK_HZ=100_000_000, EXP_PERIOD_10K=10000, SYNC_STAGES=2.
- One sub-module: sync_edge_detect (clk, rst_n, async_in -> level, rise, fall). It contains the 2-flop synchroniser plus the history flop and is reusable for buttons and other async inputs.

Test Plan:
- Reset/idle: hold rst_n=0, toggle clk_in; release with clk_in low and no edges -> all outputs 0 for 2,000,000 cycles, timeout stays 0.
- Nominal 10 kHz (clk_in high 5000, low 5000 clk cycles), 6 periods:
  - meas_valid pulses 5 times, each with period=10000 and high_time=5000;
  - locked rises on the 4th meas_valid;
  - each meas_valid pulse lasts exactly 1 cycle.
- Tolerance edges:
  - periods 10002 and 9998 keep locked=1;
  - one period of 10003 drops locked in that meas_valid cycle;
  - locked re-asserts after 4 further 10000-cycle periods.
- Timeout (TIMEOUT=50000): lock at 10000, then hold clk_in low ->
  - timeout=1 and locked=0 exactly 50000 cycles after the last counted rise;
  - period stays 10000;
  - the next rise clears timeout with no meas_valid;
  - the following rise produces a valid measurement.
- Asymmetric duty: high 3000, low 7000 -> period=10000, high_time=3000.
- clear and async reset mid-measurement:
  - clear pulsed 4000 cycles into a period -> outputs zeroed, the next rise gives no meas_valid, and the rise after it gives period=10000;
  - rst_n asserted between clk edges -> outputs zero immediately, before the next posedge clk.
